r_ptr_stat: RTL and testbench

Read-domain pointer and status controller for the async FIFO. It is the parametrised successor to the basic read-pointer block.
- Keeps the binary and Gray read pointers and the registered empty flag, with the same behaviour as before.
- Adds an occupancy level, a programmable almost-empty flag and a sticky underflow flag.
- Sits in the rclk domain between the memory read port and the 2-flop synchroniser that carries the write pointer.

---
 rtl/r_ptr_stat.sv | 58 +++++
 tb/tb_r_ptr_stat.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/r_ptr_stat.sv
// r_ptr_stat: async-FIFO read pointer, empty flag and sticky underflow.
// Define RPTR_LEVEL_EN to build the occupancy level and the almost-empty flag.
module r_ptr_stat #(
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   rae_thresh,
  input  logic                runderflow_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);
  logic [ADDRSIZE:0] rbin, rbinnext, rgraynext;
  logic pop;
  assign pop = rinc & ~rempty;
  assign rbinnext = rbin + (ADDRSIZE+1)'(pop);
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr = rbin[ADDRSIZE-1:0];
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      rempty     <= rgraynext == rq2_wptr;
      runderflow <= (rinc & rempty) | (runderflow & ~runderflow_clr);
    end
`ifdef RPTR_LEVEL_EN
  logic [ADDRSIZE:0] rq2_wbin, rdiff;
  // each binary bit is the XOR of its Gray bit and every Gray bit above it
  for (genvar g = 0; g <= ADDRSIZE; g++) begin : g2b
    assign rq2_wbin[g] = ^(rq2_wptr >> g);
  end
  assign rdiff = rq2_wbin - rbinnext;
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= rdiff;
      ralmost_empty <= rdiff <= rae_thresh;
    end
`else
  logic unused_thresh;
  assign unused_thresh = ^rae_thresh;
  assign rlevel = '0;
  assign ralmost_empty = rempty;
`endif
endmodule

// File: tb/tb_r_ptr_stat.sv
// tb_r_ptr_stat: count-based occupancy model checked every cycle, plus directed literal checks.
module tb_r_ptr_stat;
  logic       rclk = 1'b0, rrst_n, rinc, runderflow_clr;
  logic [4:0] wr, thresh, rq2_wptr, rptr, rlevel;
  logic [3:0] raddr;
  logic       rempty, ralmost_empty, runderflow;
  int vec = 0, err = 0;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic int lv(input int x);
`ifdef RPTR_LEVEL_EN
    return x;
`else
    return 0;
`endif
  endfunction
  function automatic int ae(input int en_val, input int empty_val);
`ifdef RPTR_LEVEL_EN
    return en_val;
`else
    return empty_val;
`endif
  endfunction

  assign rq2_wptr = gray(wr);
  always #5 rclk = ~rclk;

  r_ptr_stat #(.ADDRSIZE(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .rae_thresh(thresh), .runderflow_clr(runderflow_clr), .raddr(raddr),
    .rptr(rptr), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pops counted as a read count; occupancy is writes minus reads mod 32
  logic [4:0] m_rd, m_level;
  logic       m_empty, m_ae, m_uf;
  always @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      m_rd <= 0; m_level <= 0; m_empty <= 1; m_ae <= 1; m_uf <= 0;
    end else begin
      logic [4:0] rd_n, lvl;
      rd_n = m_rd + ((rinc && !m_empty) ? 5'd1 : 5'd0);
      lvl = wr - rd_n;
      m_rd <= rd_n;
      m_level <= lvl;
      m_empty <= lvl == 0;
      m_ae <= lvl <= thresh;
      m_uf <= (rinc && m_empty) || (m_uf && !runderflow_clr);
    end

  always @(negedge rclk) begin
    chk("m_raddr", raddr, m_rd % 16);
    chk("m_rptr", rptr, gray(m_rd));
    chk("m_rempty", rempty, m_empty);
    chk("m_rlevel", rlevel, lv(m_level));
    chk("m_ralmost_empty", ralmost_empty, ae(m_ae, m_empty));
    chk("m_runderflow", runderflow, m_uf);
  end

  task automatic cyc;
    @(negedge rclk);
  endtask
  task automatic do_reset;
    rrst_n = 0;
    cyc();
    rrst_n = 1;
  endtask

  initial begin
    rrst_n = 0; rinc = 0; runderflow_clr = 0; wr = 0; thresh = 0;
    repeat (2) cyc();
    chk("rst_rempty", rempty, 1);
    chk("rst_rptr", rptr, 0);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_ae", ralmost_empty, 1);
    chk("rst_uf", runderflow, 0);
    // idle reads while empty
    rrst_n = 1; rinc = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_uf", runderflow, 1);
      chk("idle_rempty", rempty, 1);
      chk("idle_rptr", rptr, 0);
      chk("idle_raddr", raddr, 0);
    end
    rinc = 0; runderflow_clr = 1;
    cyc();
    chk("clr_uf", runderflow, 0);
    runderflow_clr = 0;
    // single read
    wr = 1;
    cyc();
    chk("sr_rempty0", rempty, 0);
    chk("sr_level1", rlevel, lv(1));
    chk("sr_ae", ralmost_empty, 0);
    rinc = 1;
    cyc();
    chk("sr_raddr", raddr, 1);
    chk("sr_rptr", rptr, 5'b00001);
    chk("sr_rempty1", rempty, 1);
    chk("sr_ae1", ralmost_empty, 1);
    rinc = 0;
    // full drain with threshold 3
    do_reset();
    wr = 16; thresh = 3;
    cyc();
    chk("dr_level16", rlevel, lv(16));
    chk("dr_rempty", rempty, 0);
    chk("dr_ae16", ralmost_empty, 0);
    rinc = 1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("dr_level", rlevel, lv(16 - k));
      chk("dr_raddr", raddr, k % 16);
      chk("dr_ae", ralmost_empty, ae((16 - k) <= 3, k == 16));
      chk("dr_rempty", rempty, k == 16);
    end
    cyc();
    chk("dr_hold_raddr", raddr, 0);
    chk("dr_hold_rptr", rptr, 5'b11000);
    rinc = 0;
    // wrap
    do_reset();
    wr = 30;
    cyc();
    rinc = 1;
    repeat (30) cyc();
    chk("wr_rptr30", rptr, 5'b10001);
    chk("wr_rempty30", rempty, 1);
    rinc = 0; wr = 2;
    cyc();
    chk("wr_level4", rlevel, lv(4));
    rinc = 1;
    cyc(); chk("wr_rptr31", rptr, 5'b10000);
    cyc(); chk("wr_rptr0", rptr, 5'b00000);
    chk("wr_raddr0", raddr, 0);
    cyc(); chk("wr_rptr1", rptr, 5'b00001);
    cyc(); chk("wr_rptr2", rptr, 5'b00011);
    chk("wr_rempty2", rempty, 1);
    // underflow set/clear race
    cyc();
    chk("uf_set", runderflow, 1);
    runderflow_clr = 1;
    cyc();
    chk("uf_race", runderflow, 1);
    rinc = 0;
    cyc();
    chk("uf_clr", runderflow, 0);
    runderflow_clr = 0;
    // async reset mid-drain
    wr = 7;
    cyc();
    rinc = 1;
    cyc();
    chk("ar_rptr_pre", rptr, gray(3));
    #2 rrst_n = 0;
    #1;
    chk("ar_rptr", rptr, 0);
    chk("ar_raddr", raddr, 0);
    chk("ar_rempty", rempty, 1);
    chk("ar_rlevel", rlevel, 0);
    chk("ar_ae", ralmost_empty, 1);
    chk("ar_uf", runderflow, 0);
    cyc();
    rrst_n = 1; rinc = 0;
    // threshold above depth keeps almost-empty set even when full
    wr = 16; thresh = 20;
    cyc();
    chk("th_level16", rlevel, lv(16));
    chk("th_ae", ralmost_empty, ae(1, 0));
    // threshold 0 tracks level-0
    thresh = 0;
    cyc();
    chk("th0_ae", ralmost_empty, 0);
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
